// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with a per-register pending (busy) scoreboard.
//   Reads are combinational, with a same-cycle write-through bypass for data
//   and busy. Writes take effect on the rising edge.
//   Parameters:
//     WID_DATA  register data width
//     WID_ADD   address width, NREG = 2**WID_ADD registers
//     ZERO_REG  1 = register 0 reads zero, ignores writes, never goes busy
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     rs1, rs2 / rs1_out,rs2_out read addresses / combinational read data
//     rd, datain, regfilemux_sel writeback address, data, enable
//     iss_valid, iss_rd          issue strobe and destination (marks pending)
//     rs1_busy, rs2_busy, hazard source-pending flags, their OR
//     busy_cnt                   registered count of pending registers
module regfile_scoreboard #(
   parameter int WID_DATA = 32,
   parameter int WID_ADD  = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WID_ADD-1:0]  rs1,
   input  logic [WID_ADD-1:0]  rs2,
   output logic [WID_DATA-1:0] rs1_out,
   output logic [WID_DATA-1:0] rs2_out,
   input  logic [WID_ADD-1:0]  rd,
   input  logic [WID_DATA-1:0] datain,
   input  logic                regfilemux_sel,
   input  logic                iss_valid,
   input  logic [WID_ADD-1:0]  iss_rd,
   output logic                rs1_busy,
   output logic                rs2_busy,
   output logic                hazard,
   output logic [WID_ADD:0]    busy_cnt
);

   localparam int NREG = 2**WID_ADD;
   localparam bit ZR   = (ZERO_REG != 0);

   logic [NREG-1:0][WID_DATA-1:0] regs_q, regs_d;
   logic [NREG-1:0]               busy_q, busy_d;
   logic [WID_ADD:0]              busy_cnt_q, busy_cnt_d;

   // wb_act: writeback active this cycle (clears busy, drives bypass).
   // wr_en:  data actually written (register 0 excluded when hardwired).
   logic wb_act, wr_en, iss_en;
   logic rs1_zero, rs2_zero;

   always_comb begin
      wb_act   = regfilemux_sel && !rst;
      wr_en    = wb_act && !(ZR && rd == '0);
      iss_en   = iss_valid && !rst && !(ZR && iss_rd == '0);
      rs1_zero = ZR && rs1 == '0;
      rs2_zero = ZR && rs2 == '0;
   end

   // Read path: bypass only on a real (non-suppressed) write; register 0
   // never bypasses because wr_en is already low for it.
   always_comb begin
      rs1_out = regs_q[rs1];
      rs2_out = regs_q[rs2];
      if (rs1_zero)                rs1_out = '0;
      else if (wr_en && rd == rs1) rs1_out = datain;
      if (rs2_zero)                rs2_out = '0;
      else if (wr_en && rd == rs2) rs2_out = datain;
   end

   always_comb begin
      rs1_busy = busy_q[rs1] && !(wb_act && rd == rs1) && !rs1_zero;
      rs2_busy = busy_q[rs2] && !(wb_act && rd == rs2) && !rs2_zero;
      hazard   = rs1_busy || rs2_busy;
   end

   // Next state. Issue is applied after writeback clear so that issue wins
   // when both target the same register.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (rst) begin
         regs_d = '0;
         busy_d = '0;
      end else begin
         if (wr_en)  regs_d[rd] = datain;
         if (wb_act) busy_d[rd] = 1'b0;
         if (iss_en) busy_d[iss_rd] = 1'b1;
      end
      busy_cnt_d = '0;
      for (int i = 0; i < NREG; i++)
         busy_cnt_d = busy_cnt_d + (WID_ADD+1)'(busy_d[i]);
   end

   always_ff @(posedge clk) begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
   end

   assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a monitor on the falling
// edge pops and compares against what the DUT shows in that cycle.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd, iss_rd;
   logic [31:0] rs1_out, rs2_out, datain;
   logic        regfilemux_sel, iss_valid;
   logic        rs1_busy, rs2_busy, hazard;
   logic [5:0]  busy_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] o1, o2;
      logic        b1, b2, hz;
      logic [5:0]  cnt;
   } exp_t;

   exp_t exp_q[$];

   regfile_scoreboard #(.WID_DATA(32), .WID_ADD(5), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .rs1(rs1), .rs2(rs2), .rs1_out(rs1_out), .rs2_out(rs2_out),
      .rd(rd), .datain(datain), .regfilemux_sel(regfilemux_sel),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
      end
   endtask

   // Monitor: outputs are stable mid-cycle, compare on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.name, "rs1_out",  rs1_out,          e.o1);
         chk(e.name, "rs2_out",  rs2_out,          e.o2);
         chk(e.name, "rs1_busy", 32'(rs1_busy),    32'(e.b1));
         chk(e.name, "rs2_busy", 32'(rs2_busy),    32'(e.b2));
         chk(e.name, "hazard",   32'(hazard),      32'(e.hz));
         chk(e.name, "busy_cnt", 32'(busy_cnt),    32'(e.cnt));
      end
   end

   // One cycle: drive inputs just after the rising edge, queue expectations.
   task automatic cyc(input string nm, input logic r,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic ws, input logic [4:0] d_rd, input logic [31:0] din,
                      input logic iv, input logic [4:0] ird,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb1, input logic eb2, input logic [5:0] ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; rs1 = a1; rs2 = a2;
      regfilemux_sel = ws; rd = d_rd; datain = din;
      iss_valid = iv; iss_rd = ird;
      e.name = nm; e.o1 = e1; e.o2 = e2;
      e.b1 = eb1; e.b2 = eb2; e.hz = eb1 | eb2; e.cnt = ecnt;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; datain = '0;
      regfilemux_sel = 1'b0; iss_valid = 1'b0; iss_rd = '0;
      @(posedge clk);
      //   name            rst rs1 rs2 ws rd din           iv ird  exp1          exp2          b1 b2 cnt
      for (int a = 0; a < 32; a++)
         cyc("reset_read", 0, 5'(a), 5'(31-a), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("bypass_wr5",    0, 5,  0,  1, 5,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc("array_rd5",     0, 5,  0,  0, 0,  0,            0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc("issue7_same",   0, 5,  7,  0, 0,  0,            1, 7, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc("busy7",         0, 5,  7,  0, 0,  0,            0, 0, 32'hDEADBEEF, 0, 0, 1, 1);
      cyc("wb7_bypass",    0, 5,  7,  1, 7,  32'h77,       0, 0, 32'hDEADBEEF, 32'h77, 0, 0, 1);
      cyc("wb7_after",     0, 5,  7,  0, 0,  0,            0, 0, 32'hDEADBEEF, 32'h77, 0, 0, 0);
      cyc("issue9",        0, 9,  7,  0, 0,  0,            1, 9, 0,            32'h77, 0, 0, 0);
      cyc("iss_wb9",       0, 9,  7,  1, 9,  32'h99,       1, 9, 32'h99,       32'h77, 0, 0, 1);
      cyc("busy9_kept",    0, 9,  7,  0, 0,  0,            0, 0, 32'h99,       32'h77, 1, 0, 1);
      cyc("zero_wr_iss",   0, 0,  9,  1, 0,  32'h1234,     1, 0, 0,            32'h99, 0, 1, 1);
      cyc("zero_after",    0, 0,  9,  0, 0,  0,            0, 0, 0,            32'h99, 0, 1, 1);
      cyc("iss3_wb9",      0, 3,  9,  1, 9,  32'hAA,       1, 3, 0,            32'hAA, 0, 0, 1);
      cyc("iss3_wb9_aft",  0, 3,  9,  0, 0,  0,            0, 0, 0,            32'hAA, 1, 0, 1);
      cyc("wb3_clear",     0, 3,  9,  1, 3,  32'h33,       0, 0, 32'h33,       32'hAA, 0, 0, 1);
      cyc("wr31_bypass",   0, 3,  31, 1, 31, 32'hFFFFFFFF, 0, 0, 32'h33,       32'hFFFFFFFF, 0, 0, 0);
      cyc("rd31",          0, 3,  31, 0, 0,  0,            0, 0, 32'h33,       32'hFFFFFFFF, 0, 0, 0);
      cyc("iss1",          0, 1,  2,  0, 0,  0,            1, 1, 0,            0, 0, 0, 0);
      cyc("iss2",          0, 1,  2,  0, 0,  0,            1, 2, 0,            0, 1, 0, 1);
      cyc("iss3",          0, 1,  2,  0, 0,  0,            1, 3, 0,            0, 1, 1, 2);
      cyc("cnt3",          0, 3,  2,  0, 0,  0,            0, 0, 32'h33,       0, 1, 1, 3);
      cyc("rst_nobypass",  1, 2,  3,  1, 2,  32'h5555,     1, 4, 0,            32'h33, 1, 1, 3);
      cyc("after_rst",     0, 2,  3,  0, 0,  0,            0, 0, 0,            0, 0, 0, 0);
      cyc("after_rst2",    0, 5,  4,  0, 0,  0,            0, 0, 0,            0, 0, 0, 0);
      cyc("after_rst31",   0, 31, 9,  0, 0,  0,            0, 0, 0,            0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WID_DATA, default 32, register data width.
REQ-002 SHALL have parameter WID_ADD, default 5, register address width; register count NREG = 2**WID_ADD.
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero and never busy.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports rs1, rs2  input  WID_ADD  read addresses.
REQ-007 SHALL have ports rs1_out, rs2_out  output  WID_DATA  read data, combinational.
REQ-008 SHALL have port rd  input  WID_ADD  writeback address.
REQ-009 SHALL have port datain  input  WID_DATA  writeback data.
REQ-010 SHALL have port regfilemux_sel  input  1  writeback enable.
REQ-011 SHALL have port iss_valid  input  1  issue strobe; marks iss_rd pending.
REQ-012 SHALL have port iss_rd  input  WID_ADD  destination of the issuing instruction.
REQ-013 SHALL have ports rs1_busy, rs2_busy  output  1  source register pending, combinational.
REQ-014 SHALL have port hazard  output  1  rs1_busy OR rs2_busy.
REQ-015 SHALL have port busy_cnt  output  WID_ADD+1  registered count of pending registers.

Function
REQ-016 SHALL hold NREG data registers and NREG busy bits.
REQ-017 SHALL write datain to register rd on a rising edge when regfilemux_sel=1 and rst=0.
REQ-018 SHALL drive rsN_out = datain when regfilemux_sel=1, rst=0, rd=rsN and the write is not suppressed (write-through bypass); otherwise rsN_out = register[rsN].
REQ-019 SHALL, with ZERO_REG=1, ignore writes to address 0, drive rsN_out = 0 for rsN=0 (no bypass), and ignore issue to iss_rd=0.
REQ-020 SHALL set busy[iss_rd] on a rising edge when iss_valid=1 and rst=0.
REQ-021 SHALL clear busy[rd] on a rising edge when regfilemux_sel=1 and rst=0; writing a non-busy register is legal and leaves it clear.
REQ-022 SHALL, on simultaneous issue and writeback to the same register, leave that busy bit set (issue wins); data is still written.
REQ-023 SHALL, on simultaneous issue and writeback to different registers, apply both.
REQ-024 SHALL drive rsN_busy = busy[rsN] AND NOT (regfilemux_sel=1, rst=0, rd=rsN); the writeback bypasses the pending state in the same cycle.
REQ-025 SHALL drive rsN_busy = 0 for rsN=0 when ZERO_REG=1.
REQ-026 SHALL not let an issue in cycle t affect rsN_busy until cycle t+1.
REQ-027 SHALL update busy_cnt on the same edge as the busy bits, equal to the population count of the next busy vector; range 0..NREG (NREG-1 with ZERO_REG=1), no wrap.
REQ-028 SHALL have zero-cycle read latency and one-cycle write latency (a write is visible from the array in the following cycle, and via bypass in the same cycle).

Reset
REQ-029 SHALL, on a rising edge with rst=1, clear all data registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-030 SHALL give rst priority over writeback and issue in the same cycle; neither takes effect.
REQ-031 SHALL suppress bypass of data and busy while rst=1; reads return array contents.
REQ-032 SHALL resume normal operation on the first edge with rst=0 after reset, with no pending state retained.

Verification
REQ-033 SHALL cover: rst 1 cycle; read all addresses -> rsN_out=0, rsN_busy=0, busy_cnt=0.
REQ-034 SHALL cover: write rd=5 with 0xDEADBEEF and rs1=5 in the same cycle -> rs1_out=0xDEADBEEF in that cycle; next cycle with regfilemux_sel=0, rs1_out=0xDEADBEEF.
REQ-035 SHALL cover: issue iss_rd=7; next cycle rs2=7 -> rs2_busy=1, hazard=1, busy_cnt=1; writeback rd=7 -> rs2_busy=0 in that cycle, busy_cnt=0 after the edge.
REQ-036 SHALL cover: issue and writeback both to register 9 in one cycle -> busy[9] stays 1, register[9]=datain, busy_cnt unchanged at 1 if it was already pending.
REQ-037 SHALL cover: ZERO_REG=1, write 0x1234 to rd=0 and issue iss_rd=0 -> rs1=0 reads 0, rs1_busy=0, busy_cnt=0.
REQ-038 SHALL cover: issue to registers 1..3 (busy_cnt=3), then assert rst together with a write to 2 -> all busy bits clear, busy_cnt=0, register[2]=0.
